// File: rtl/fir_errmon_pkg.sv
// Shared types and width helpers for the FIR error-metric monitor.
// Optional sum-of-squared-error path is enabled with FIR_ERRMON_MSE_EN.
package fir_errmon_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Accumulator width: WINDOW samples of |d| (or d^2 when squared is set) cannot overflow.
  function automatic int acc_width(input int w, input int log2_win, input bit squared);
    return squared ? (2 * w + log2_win) : (w + log2_win);
  endfunction

endpackage

// File: rtl/errmon_absdiff.sv
// Stage 1 of the error monitor: registered |y_exact - y_approx| and its valid flag.
// With FIR_ERRMON_MSE_EN defined the stage also registers the squared error.
module errmon_absdiff #(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                in_valid,
  input  logic signed [W-1:0] y_exact,
  input  logic signed [W-1:0] y_approx,
  output logic                valid,
  output logic [W-1:0]        absd
`ifdef FIR_ERRMON_MSE_EN
  ,
  output logic [2*W-1:0]      sq
`endif
);

  logic [W:0]   diff;
  logic [W-1:0] abs_next;

  // One extra bit keeps the difference exact; its magnitude always fits W unsigned bits.
  always_comb begin
    diff     = {y_exact[W-1], y_exact} - {y_approx[W-1], y_approx};
    abs_next = diff[W] ? W'(-diff) : diff[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      valid <= 1'b0;
      absd  <= '0;
    end else begin
      valid <= in_valid;
      absd  <= abs_next;
    end
  end

`ifdef FIR_ERRMON_MSE_EN
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sq <= '0;
    end else begin
      sq <= (2*W)'(abs_next) * (2*W)'(abs_next);
    end
  end
`endif

endmodule

// File: rtl/fir_err_monitor.sv
// Windowed error-metric monitor comparing exact and approximate FIR outputs.
// Define FIR_ERRMON_MSE_EN to build the sum-of-squared-error accumulator (sse).
module fir_err_monitor
  import fir_errmon_pkg::*;
#(
  parameter int W        = 16,
  parameter int WINDOW   = 1024,
  parameter int LOG2_WIN = $clog2(WINDOW)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic                                      in_valid,
  input  logic signed [W-1:0]                       y_exact,
  input  logic signed [W-1:0]                       y_approx,
  output logic                                      busy,
  output logic                                      done,
  output logic [acc_width(W, LOG2_WIN, 1'b0)-1:0]   sae,
  output logic [W-1:0]                              max_ae,
  output logic [LOG2_WIN:0]                         err_cnt,
  output logic [W-1:0]                              mae,
  output logic [acc_width(W, LOG2_WIN, 1'b1)-1:0]   sse
);

  localparam int SAE_W = acc_width(W, LOG2_WIN, 1'b0);
  localparam int SSE_W = acc_width(W, LOG2_WIN, 1'b1);
  localparam logic [LOG2_WIN:0] LAST = (LOG2_WIN+1)'(WINDOW - 1);

  state_t            state;
  logic [LOG2_WIN:0] cnt;
  logic              accept;
  logic              clr;
  logic              s1_valid;
  logic [W-1:0]      s1_abs;

  assign accept = (state == RUN) && in_valid;
  assign clr    = start && ((state == IDLE) || (state == DONE));

  // Control FSM; busy and done are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        RUN: begin
          if (in_valid) begin
            cnt <= cnt + (LOG2_WIN+1)'(1);
            if (cnt == LAST) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIR_ERRMON_MSE_EN
  logic [2*W-1:0] s1_sq;
`endif

  errmon_absdiff #(.W(W)) u_absdiff (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (accept),
    .y_exact  (y_exact),
    .y_approx (y_approx),
    .valid    (s1_valid),
    .absd     (s1_abs)
`ifdef FIR_ERRMON_MSE_EN
    ,
    .sq       (s1_sq)
`endif
  );

  // Stage 2: the last sample lands here during DRAIN, so results are final in DONE.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sae     <= '0;
      max_ae  <= '0;
      err_cnt <= '0;
    end else if (s1_valid) begin
      sae <= sae + SAE_W'(s1_abs);
      if (s1_abs > max_ae) begin
        max_ae <= s1_abs;
      end
      if (s1_abs != '0) begin
        err_cnt <= err_cnt + (LOG2_WIN+1)'(1);
      end
    end
  end

`ifdef FIR_ERRMON_MSE_EN
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sse <= '0;
    end else if (s1_valid) begin
      sse <= sse + SSE_W'(s1_sq);
    end
  end
`else
  assign sse = '0;
`endif

  assign mae = sae[SAE_W-1:LOG2_WIN];

endmodule

// File: tb/tb_fir_err_monitor.sv
// Scoreboard bench for fir_err_monitor with a sample-list reference model (WINDOW=4).
// Honours FIR_ERRMON_MSE_EN when deciding the expected sse.
module tb_fir_err_monitor;

  localparam int W        = 16;
  localparam int WINDOW   = 4;
  localparam int LOG2_WIN = 2;

  logic                         clk = 1'b0;
  logic                         rst, start, in_valid;
  logic signed [W-1:0]          y_exact, y_approx;
  logic                         busy, done;
  logic [W+LOG2_WIN-1:0]        sae;
  logic [W-1:0]                 max_ae;
  logic [LOG2_WIN:0]            err_cnt;
  logic [W-1:0]                 mae;
  logic [2*W+LOG2_WIN-1:0]      sse;

  always #5 clk = ~clk;

  fir_err_monitor #(.W(W), .WINDOW(WINDOW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .y_exact  (y_exact),
    .y_approx (y_approx),
    .busy     (busy),
    .done     (done),
    .sae      (sae),
    .max_ae   (max_ae),
    .err_cnt  (err_cnt),
    .mae      (mae),
    .sse      (sse)
  );

  typedef struct {
    int     cyc;
    longint sae;
    longint max_ae;
    longint err_cnt;
    longint sse;
  } result_t;

  result_t exp_q[$];
  result_t exp_hold[int];
  bit      exp_busy[int];
  bit      exp_zero[int];
  result_t last_res;

  int total = 0;
  int bad   = 0;

  bit     running = 0;
  bit     known   = 0;
  int     drain_cyc = -10;
  int     done_cyc  = -10;
  longint samples[$];

  // Cycle n spans posedge n to posedge n+1 (posedge n at time 5+10n).
  function automatic int cur_cycle();
    return int'(($time - 64'd5) / 64'd10);
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cur_cycle(), act, req);
    end
  endtask

  // Metrics of a finished window computed straight from the list of accepted pairs' errors.
  function automatic result_t summarize(input int cyc);
    result_t r;
    r.cyc = cyc; r.sae = 0; r.max_ae = 0; r.err_cnt = 0; r.sse = 0;
    foreach (samples[i]) begin
      r.sae += samples[i];
      if (samples[i] > r.max_ae) r.max_ae = samples[i];
      if (samples[i] != 0) r.err_cnt++;
`ifdef FIR_ERRMON_MSE_EN
      r.sse += samples[i] * samples[i];
`endif
    end
    return r;
  endfunction

  task automatic applyStimulus(input bit s, input bit r, input bit v,
                               input logic signed [W-1:0] e, input logic signed [W-1:0] a);
    int     n;
    bit     starting;
    longint d;
    n = cur_cycle();
    start = s; rst = r; in_valid = v; y_exact = e; y_approx = a;
    if (known) exp_busy[n] = running || (n == drain_cyc);
    if (r) begin
      running   = 0;
      known     = 1;
      drain_cyc = -10;
      done_cyc  = -10;
      exp_busy[n+1] = 1'b0;
      exp_zero[n+1] = 1'b1;
    end else begin
      starting = s && !running && (n != drain_cyc);
      if (known && n == done_cyc && !starting) exp_hold[n+1] = last_res;
      if (running && v) begin
        d = longint'(e) - longint'(a);
        if (d < 0) d = -d;
        samples.push_back(d);
        if (samples.size() == WINDOW) begin
          running   = 0;
          drain_cyc = n + 1;
          done_cyc  = n + 2;
          last_res  = summarize(n + 2);
          exp_q.push_back(last_res);
        end
      end else if (starting) begin
        running = 1;
        samples.delete();
        exp_zero[n+1] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic genPair(output logic signed [W-1:0] e, output logic signed [W-1:0] a);
    case ($urandom_range(0, 3))
      0: begin e = W'($urandom); a = W'($urandom); end
      1: begin e = W'($urandom); a = e - W'($urandom_range(0, 6)) + W'(3); end
      2: begin e = W'($urandom); a = e; end
      default: begin
        e = ($urandom_range(0, 1) == 0) ? 16'sh7fff : 16'sh8000;
        a = ($urandom_range(0, 1) == 0) ? 16'sh7fff : 16'sh8000;
      end
    endcase
  endtask

  task automatic finishRun();
    logic signed [W-1:0] e, a;
    for (int k = 0; k < 40 && running; k++) begin
      genPair(e, a);
      applyStimulus(1'b0, 1'b0, 1'b1, e, a);
    end
  endtask

  // Monitor: pops expected results on each done pulse and checks per-cycle expectations.
  always @(negedge clk) begin
    int      n;
    result_t r;
    n = cur_cycle();
    if (exp_busy.exists(n)) checkOutput("busy", longint'(busy), longint'(exp_busy[n]));
    if (exp_zero.exists(n)) begin
      checkOutput("clr_sae", longint'(sae), 0);
      checkOutput("clr_max_ae", longint'(max_ae), 0);
      checkOutput("clr_err_cnt", longint'(err_cnt), 0);
      checkOutput("clr_mae", longint'(mae), 0);
      checkOutput("clr_sse", longint'(sse), 0);
      checkOutput("clr_done", longint'(done), 0);
    end
    if (exp_hold.exists(n)) begin
      r = exp_hold[n];
      checkOutput("hold_sae", longint'(sae), r.sae);
      checkOutput("hold_max_ae", longint'(max_ae), r.max_ae);
      checkOutput("hold_err_cnt", longint'(err_cnt), r.err_cnt);
    end
    while (exp_q.size() > 0 && exp_q[0].cyc < n) begin
      checkOutput("done_missing", longint'(n), longint'(exp_q[0].cyc));
      void'(exp_q.pop_front());
    end
    if (done === 1'b1) begin
      if (exp_q.size() == 0 || exp_q[0].cyc != n) begin
        checkOutput("done_unexpected", longint'(done), 0);
      end else begin
        r = exp_q.pop_front();
        checkOutput("sae", longint'(sae), r.sae);
        checkOutput("max_ae", longint'(max_ae), r.max_ae);
        checkOutput("err_cnt", longint'(err_cnt), r.err_cnt);
        checkOutput("mae", longint'(mae), r.sae >> LOG2_WIN);
        checkOutput("sse", longint'(sse), r.sse);
      end
    end
  end

  initial begin
    logic signed [W-1:0] e, a;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; y_exact = '0; y_approx = '0;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 0);

    // in_valid before start must not count
    repeat (3) begin genPair(e, a); applyStimulus(1'b0, 1'b0, 1'b1, e, a); end

    // Directed run; the sample presented with start is dropped
    applyStimulus(1'b1, 1'b0, 1'b1, 99, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 10, 10);
    applyStimulus(1'b0, 1'b0, 1'b1, 10, 7);
    applyStimulus(1'b0, 1'b0, 1'b1, -5, -1);
    applyStimulus(1'b0, 1'b0, 1'b1, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 500, -500);
    applyStimulus(1'b0, 1'b0, 1'b1, 500, -500);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);

    // Extreme pairs with gaps and a start during RUN
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < WINDOW; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32767, -32768);
      if (i < WINDOW - 1) applyStimulus(i == 1, 1'b0, 1'b0, 0, 0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
    // start in the done cycle, then the directed pairs again with gaps
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 10, 10);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 10, 7);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, -5, -1);
    applyStimulus(1'b0, 1'b0, 1'b1, 0, 0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);

    // Reset after two samples aborts the run without a done pulse
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 100, -3);
    applyStimulus(1'b0, 1'b0, 1'b1, -7, 20);
    applyStimulus(1'b0, 1'b1, 1'b1, 1, 2);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b1, 3, 4);

    // Randomized runs with random gaps, stray starts and tails
    for (int run = 0; run < 20; run++) begin
      genPair(e, a);
      applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)), e, a);
      for (int k = 0; k < 60 && running; k++) begin
        genPair(e, a);
        applyStimulus($urandom_range(0, 9) == 0, 1'b0, $urandom_range(0, 9) < 7, e, a);
      end
      repeat ($urandom_range(0, 3)) begin
        genPair(e, a);
        applyStimulus($urandom_range(0, 3) == 0, 1'b0, 1'($urandom_range(0, 1)), e, a);
      end
    end
    finishRun();
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);

    checkOutput("pending_results", longint'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
